// File: rtl/mpy_pkg.sv
// rtl/mpy_pkg.sv - shared types, default widths and helpers for the product accumulator
package mpy_pkg;

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int LEN_W_DEF  = 8;

  // Widest supported operands; callers cast down to their own ACC_W.
  localparam int PROD_W_MAX = 128;
  localparam int ACC_W_MAX  = 128;

  function automatic logic [ACC_W_MAX-1:0] zext_prod(input logic [PROD_W_MAX-1:0] product);
    return ACC_W_MAX'(product);
  endfunction

endpackage

// File: rtl/mpy_acc_pending.sv
// rtl/mpy_acc_pending.sv - one-entry product holding register with full flag and drop indication
module mpy_acc_pending #(
  parameter int W = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] data,
  output logic         full,
  output logic [W-1:0] q,
  output logic         drop
);

  // A simultaneous take frees the slot, so the new product still fits.
  assign drop = load & full & ~take;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full <= 1'b0;
      q    <= '0;
    end else if (clear) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load && (!full || take)) begin
      full <= 1'b1;
      q    <= data;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mpy_result_acc.sv
// rtl/mpy_result_acc.sv - accumulates N multiplier products per sum and hands sums downstream
module mpy_result_acc
  import mpy_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PROD_W-1:0] Product_In,
  input  logic              Product_In_Valid,
  input  logic [LEN_W-1:0]  Acc_Len,
  input  logic              Acc_Clear,
  output logic [ACC_W-1:0]  Sum_Out,
  output logic              Sum_Valid,
  input  logic              Sum_Ready,
  output logic              Overflow,
  output logic              Drop_Err
);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len_q;

  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  pend_ext;
  logic [ACC_W-1:0]  term;
  logic [ACC_W:0]    sum_full;
  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W-1:0]  count_nx;
  logic              xfer;
  logic              have_term;
  logic              pend_full;
  logic              pend_load;
  logic              pend_take;
  logic              pend_drop;
  logic [PROD_W-1:0] pend_q;

  mpy_acc_pending #(.W(PROD_W)) u_pending (
    .CLK   (CLK),
    .RST   (RST),
    .clear (Acc_Clear),
    .load  (pend_load),
    .take  (pend_take),
    .data  (Product_In),
    .full  (pend_full),
    .q     (pend_q),
    .drop  (pend_drop)
  );

  // A held product is older than any new pulse, so it is always consumed first.
  always_comb begin
    prod_ext  = ACC_W'(zext_prod(PROD_W_MAX'(Product_In)));
    pend_ext  = ACC_W'(zext_prod(PROD_W_MAX'(pend_q)));
    len_in    = (Acc_Len == '0) ? LEN_W'(1) : Acc_Len;
    len_eff   = (count == '0) ? len_in : len_q;
    count_nx  = count + LEN_W'(1);
    xfer      = (state == ST_HOLD) && Sum_Ready;
    term      = prod_ext;
    have_term = 1'b0;
    pend_take = 1'b0;
    pend_load = 1'b0;
    if (state == ST_ACC || xfer) begin
      if (pend_full) begin
        term      = pend_ext;
        have_term = 1'b1;
        pend_take = 1'b1;
        pend_load = Product_In_Valid;
      end else begin
        have_term = Product_In_Valid;
      end
    end else begin
      pend_load = Product_In_Valid;
    end
    // acc and count are zero in ST_HOLD, so a new first term shares this adder.
    sum_full  = {1'b0, acc} + {1'b0, term};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_ACC;
      acc       <= '0;
      count     <= '0;
      len_q     <= '0;
      Sum_Out   <= '0;
      Sum_Valid <= 1'b0;
      Overflow  <= 1'b0;
      Drop_Err  <= 1'b0;
    end else if (Acc_Clear) begin
      state     <= ST_ACC;
      acc       <= '0;
      count     <= '0;
      len_q     <= '0;
      Sum_Out   <= '0;
      Sum_Valid <= 1'b0;
      Overflow  <= 1'b0;
      Drop_Err  <= 1'b0;
    end else begin
      if (pend_drop)
        Drop_Err <= 1'b1;
      if (have_term) begin
        if (count == '0)
          len_q <= len_in;
        if (sum_full[ACC_W])
          Overflow <= 1'b1;
        if (count_nx == len_eff) begin
          Sum_Out   <= sum_full[ACC_W-1:0];
          Sum_Valid <= 1'b1;
          acc       <= '0;
          count     <= '0;
          state     <= ST_HOLD;
        end else begin
          acc       <= sum_full[ACC_W-1:0];
          count     <= count_nx;
          Sum_Valid <= 1'b0;
          state     <= ST_ACC;
        end
      end else if (xfer) begin
        Sum_Valid <= 1'b0;
        state     <= ST_ACC;
      end
    end
  end

endmodule

// File: tb/tb_mpy_result_acc.sv
// tb/tb_mpy_result_acc.sv - randomized and directed bench for mpy_result_acc against a queue-based model
module tb_mpy_result_acc;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [63:0] Product_In = '0;
  logic        Product_In_Valid = 1'b0;
  logic [7:0]  Acc_Len = '0;
  logic        Acc_Clear = 1'b0;
  logic        Sum_Ready = 1'b0;
  logic [71:0] Sum_Out;
  logic        Sum_Valid, Overflow, Drop_Err;
  logic [63:0] s64_out;
  logic        s64_valid, s64_ovf, s64_drp;

  int checks = 0;
  int errors = 0;

  mpy_result_acc dut (
    .CLK(CLK), .RST(RST), .Product_In(Product_In), .Product_In_Valid(Product_In_Valid),
    .Acc_Len(Acc_Len), .Acc_Clear(Acc_Clear), .Sum_Out(Sum_Out), .Sum_Valid(Sum_Valid),
    .Sum_Ready(Sum_Ready), .Overflow(Overflow), .Drop_Err(Drop_Err)
  );

  mpy_result_acc #(.ACC_W(64)) dut64 (
    .CLK(CLK), .RST(RST), .Product_In(Product_In), .Product_In_Valid(Product_In_Valid),
    .Acc_Len(Acc_Len), .Acc_Clear(Acc_Clear), .Sum_Out(s64_out), .Sum_Valid(s64_valid),
    .Sum_Ready(Sum_Ready), .Overflow(s64_ovf), .Drop_Err(s64_drp)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: sums formed from an ordered stream of accepted products.
  bit          m_valid;
  bit [71:0]   m_out;
  bit [71:0]   m_part;
  int          m_cnt;
  int          m_len;
  bit          m_ovf;
  bit          m_drp;
  bit [63:0]   m_pend[$];

  function automatic void m_reset();
    m_valid = 0; m_out = '0; m_part = '0; m_cnt = 0; m_len = 0;
    m_ovf = 0; m_drp = 0; m_pend.delete();
  endfunction

  function automatic void m_add(bit [63:0] t, int lin);
    bit [72:0] s;
    if (m_cnt == 0) m_len = (lin == 0) ? 1 : lin;
    s = {1'b0, m_part} + {9'b0, t};
    if (s[72]) m_ovf = 1;
    m_part = s[71:0];
    m_cnt++;
    if (m_cnt == m_len) begin
      m_out = m_part; m_valid = 1; m_part = '0; m_cnt = 0;
    end
  endfunction

  function automatic void m_step(bit pv, bit [63:0] p, int lin, bit clr, bit rdy);
    bit [63:0] t;
    bit have;
    if (clr) begin m_reset(); return; end
    if (m_valid && !rdy) begin
      if (pv) begin
        if (m_pend.size() == 0) m_pend.push_back(p);
        else m_drp = 1;
      end
      return;
    end
    m_valid = 0;
    have = 0;
    t = '0;
    if (m_pend.size() > 0) begin
      t = m_pend.pop_front(); have = 1;
      if (pv) m_pend.push_back(p);
    end else if (pv) begin
      t = p; have = 1;
    end
    if (have) m_add(t, lin);
  endfunction

  task automatic tick();
    bit pv = Product_In_Valid;
    bit [63:0] p = Product_In;
    int lin = int'(Acc_Len);
    bit clr = Acc_Clear;
    bit rdy = Sum_Ready;
    @(posedge CLK);
    m_step(pv, p, lin, clr, rdy);
    #1;
    chk("valid", Sum_Valid, m_valid);
    chk("sum", Sum_Out, m_out);
    chk("ovf", Overflow, m_ovf);
    chk("drop", Drop_Err, m_drp);
  endtask

  task automatic pulse(input logic [63:0] p);
    Product_In = p; Product_In_Valid = 1'b1;
    tick();
    Product_In_Valid = 1'b0;
  endtask

  task automatic clear();
    Acc_Clear = 1'b1; tick(); Acc_Clear = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_sum", Sum_Out, 0);
    chk("rst_valid", Sum_Valid, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_drop", Drop_Err, 0);
    RST = 1'b1;

    // 1: three spaced products, one-cycle valid
    clear(); Acc_Len = 3; Sum_Ready = 1;
    pulse(5); repeat (32) tick(); pulse(7); repeat (32) tick(); pulse(9);
    chk("t1_valid", Sum_Valid, 1); chk("t1_sum", Sum_Out, 21);
    tick();
    chk("t1_one_cycle", Sum_Valid, 0); chk("t1_ovf", Overflow, 0); chk("t1_drop", Drop_Err, 0);

    // 2: pending slot and drop while held
    clear(); Acc_Len = 1; Sum_Ready = 0;
    pulse(64'h10);
    chk("t2_valid", Sum_Valid, 1); chk("t2_sum", Sum_Out, 64'h10);
    pulse(64'h20); pulse(64'h30);
    chk("t2_drop", Drop_Err, 1); chk("t2_held", Sum_Out, 64'h10);
    Sum_Ready = 1; tick(); Sum_Ready = 0;
    chk("t2_reload_valid", Sum_Valid, 1); chk("t2_reload_sum", Sum_Out, 64'h20);
    Sum_Ready = 1; tick();
    chk("t2_empty", Sum_Valid, 0);

    // 3: carry into the extra bits vs wrap on a 64-bit accumulator
    clear(); Acc_Len = 2; Sum_Ready = 1;
    pulse('1); pulse('1);
    chk("t3_sum72", Sum_Out, 72'h1_FFFF_FFFF_FFFF_FFFE); chk("t3_ovf72", Overflow, 0);
    chk("t3_valid64", s64_valid, 1);
    chk("t3_sum64", s64_out, 64'hFFFF_FFFF_FFFF_FFFE); chk("t3_ovf64", s64_ovf, 1);
    tick();

    // 4: async reset mid-sum leaves no residue
    clear(); Acc_Len = 4;
    pulse(3); pulse(4);
    #3; RST = 1'b0; #1;
    chk("t4_sum", Sum_Out, 0); chk("t4_valid", Sum_Valid, 0);
    chk("t4_ovf", Overflow, 0); chk("t4_drop", Drop_Err, 0);
    m_reset();
    @(posedge CLK); #2; RST = 1'b1;
    Acc_Len = 1; pulse(6);
    chk("t4_after_valid", Sum_Valid, 1); chk("t4_after_sum", Sum_Out, 6);
    tick();

    // 5: clear discards coincident product silently
    clear(); Acc_Len = 2;
    pulse(8);
    Acc_Clear = 1; Product_In = 9; Product_In_Valid = 1; tick();
    Acc_Clear = 0; Product_In_Valid = 0;
    chk("t5_valid", Sum_Valid, 0); chk("t5_drop", Drop_Err, 0);
    pulse(1); pulse(2);
    chk("t5_valid2", Sum_Valid, 1); chk("t5_sum", Sum_Out, 3);
    tick();

    // 6: zero length acts as one; length latched at the first term
    clear(); Acc_Len = 0;
    pulse(64'hABCD);
    chk("t6_valid", Sum_Valid, 1); chk("t6_sum", Sum_Out, 64'hABCD);
    tick();
    Acc_Len = 3; pulse(1); Acc_Len = 2; pulse(2);
    chk("t6_mid", Sum_Valid, 0);
    pulse(3);
    chk("t6_valid2", Sum_Valid, 1); chk("t6_sum2", Sum_Out, 6);
    tick();

    // Random traffic against the model
    clear();
    for (int i = 0; i < 3000; i++) begin
      Product_In_Valid = ($urandom_range(0, 9) < 4);
      Product_In = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      Sum_Ready = ($urandom_range(0, 1) == 1);
      Acc_Clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) Acc_Len = 8'($urandom_range(0, 4));
      tick();
    end
    Product_In_Valid = 0; Acc_Clear = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpy_result_acc.md
Name: mpy_result_acc

Overview:
- Downstream consumer of the 32x32 shift-add multiplier.
- Captures each 64-bit product on the multiplier's one-cycle valid pulse and accumulates a programmable number of products into a wide unsigned sum.
- Presents each finished sum on a valid/ready interface to the next stage.
- The multiplier cannot be stalled, so one product arriving while a sum is held goes into a single pending register. Further products are dropped and flagged.

Parameters:
- PROD_W, 64, product input width
- ACC_W, 72, accumulator/sum width (must be >= PROD_W)
- LEN_W, 8, width of the products-per-sum field

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset (0 = reset)
- Product_In  in  PROD_W  unsigned product from multiplier
- Product_In_Valid  in  1  one-cycle pulse, Product_In valid this cycle
- Acc_Len  in  LEN_W  products per sum; 0 treated as 1
- Acc_Clear  in  1  synchronous abort/clear, single cycle
- Sum_Out  out  ACC_W  accumulated sum
- Sum_Valid  out  1  Sum_Out valid, held until accepted
- Sum_Ready  in  1  downstream accept
- Overflow  out  1  sticky, carry out of accumulator since last clear
- Drop_Err  out  1  sticky, a product was discarded since last clear

Behaviour:
- Reset (RST=0, async): state=ST_ACC, acc=0, count=0, len_q=0, pending empty, Sum_Out=0, Sum_Valid=0, Overflow=0, Drop_Err=0.
- Reset mid-accumulation or mid-hold discards everything; there is no partial output.
- Priority each cycle: reset > Acc_Clear > handshake/accumulate.
- Acc_Clear: same effect as reset except it is synchronous. A product pulsing in the same cycle is discarded and Drop_Err is not set.

ST_ACC (accumulating, Sum_Valid=0):
- Product pulse with count==0: len_q <= max(Acc_Len,1). Acc_Len is sampled only here.
- Each product pulse: acc <= acc + Product_In (zero-extended). Carry out of bit ACC_W-1 sets Overflow; acc wraps mod 2^ACC_W.
- count increments. When the new count equals len_q: Sum_Out <= the new sum, Sum_Valid <= 1, acc <= 0, count <= 0, go to ST_HOLD.
- Latency: Sum_Valid rises the cycle after the last product pulse.

ST_HOLD (Sum_Valid=1, Sum_Out stable):
- Transfer occurs on Sum_Valid && Sum_Ready.
- Product pulse with no transfer: if pending is empty, store it. If pending is full, discard the product and set Drop_Err.
- Transfer with pending full: the pending value becomes the first term of the next sum (acc=pending, count=1, len_q resampled from Acc_Len), pending is cleared. If len_q==1, reload Sum_Out with it and stay in ST_HOLD (Sum_Valid stays 1). Otherwise go to ST_ACC.
- Transfer with pending empty and a product pulse in the same cycle: the product becomes the first term, handled exactly like the pending case above.
- Transfer with neither: Sum_Valid <= 0, go to ST_ACC.
- Pending full, transfer, and a new pulse all in the same cycle: pending becomes the first term and the new product is stored into pending. Nothing is dropped.

General:
- Sum_Out holds its last value when Sum_Valid=0.
- Overflow and Drop_Err clear only on reset or Acc_Clear.

Decomposition:
- Shared package mpy_pkg holds:
  - state enum {ST_ACC, ST_HOLD}
  - PROD_W/ACC_W/LEN_W defaults
  - function zext_prod(product) -> ACC_W
- One natural sub-module: mpy_acc_pending, a one-entry product holding register with full flag, load/take controls and a drop indication.
- The FSM, accumulator and output register stay in the top.

Test Plan:
1. Acc_Len=3, pulses of 5, 7, 9 spaced 33 cycles, Sum_Ready=1 -> Sum_Out=21, Sum_Valid high one cycle after the third pulse for exactly one cycle; Overflow=0, Drop_Err=0.
2. Acc_Len=1, Sum_Ready=0, pulses 0x10, 0x20, 0x30 -> Sum_Out=0x10 held. 0x20 goes to pending, 0x30 sets Drop_Err=1. Raise Sum_Ready for one cycle -> next Sum_Out=0x20, Sum_Valid stays 1.
3. Acc_Len=2, two pulses of 0xFFFF_FFFF_FFFF_FFFF with ACC_W=72 -> Sum_Out=0x1_FFFF_FFFF_FFFF_FFFE, Overflow=0. Repeat with ACC_W=64 -> Sum_Out=0xFFFF_FFFF_FFFF_FFFE, Overflow=1.
4. Acc_Len=4, two pulses (3, 4), then RST low for 1 cycle (async, mid-clock) -> all outputs 0 immediately. After release, Acc_Len=1 and pulse 6 -> Sum_Out=6, i.e. no residue.
5. Acc_Len=2, pulse 8, then Acc_Clear coincident with pulse 9 -> no Sum_Valid, Drop_Err=0. Next pulses 1, 2 -> Sum_Out=3.
6. Acc_Len=0, single pulse 0xABCD -> treated as length 1, Sum_Out=0xABCD one cycle later. Acc_Len changed to 2 mid-sum does not affect a sum already in progress.
